// File: rtl/CPU_def.sv
// CPU_def: shared forwarding-select and hazard-FSM types for the pipeline controller
package CPU_def;
  localparam int REG_ADDR_BITS = 5;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} hz_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-side signals seen by the hazard controller
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_BITS = CPU_def::REG_ADDR_BITS,
  parameter int PERF_BITS = 32
);
  logic [REG_ADDR_BITS-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [REG_ADDR_BITS-1:0] write_reg_e, write_reg_m, write_reg_wb;
  logic reg_write_e, reg_write_m, reg_write_wb;
  logic mem_to_reg_e, mem_to_reg_m;
  logic branch_d, branch_taken_d, jump_d;
  logic mem_req_m, mem_ready;
  logic en_f, en_d, en_e, en_m, en_wb;
  logic flush_d, flush_e, flush_wb;
  logic fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic timeout_err;
  logic [PERF_BITS-1:0] stall_cycles;
  modport master (
    output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_wb,
    output reg_write_e, reg_write_m, reg_write_wb, mem_to_reg_e, mem_to_reg_m,
    output branch_d, branch_taken_d, jump_d, mem_req_m, mem_ready,
    input en_f, en_d, en_e, en_m, en_wb, flush_d, flush_e, flush_wb,
    input fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, timeout_err, stall_cycles
  );
  modport slave (
    input rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_wb,
    input reg_write_e, reg_write_m, reg_write_wb, mem_to_reg_e, mem_to_reg_m,
    input branch_d, branch_taken_d, jump_d, mem_req_m, mem_ready,
    output en_f, en_d, en_e, en_m, en_wb, flush_d, flush_e, flush_wb,
    output fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, timeout_err, stall_cycles
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: register-match comparators for forwarding selects and stall detection
module hazard_forward_unit
  import CPU_def::*;
#(
  parameter int W = REG_ADDR_BITS
) (
  input  logic [W-1:0] rs_d, rt_d, rs_e, rt_e,
  input  logic [W-1:0] write_reg_e, write_reg_m, write_reg_wb,
  input  logic         reg_write_e, reg_write_m, reg_write_wb,
  input  logic         mem_to_reg_e, mem_to_reg_m, branch_d,
  output fwd_sel_t     fwd_a_e, fwd_b_e,
  output logic         fwd_a_d, fwd_b_d, load_stall, branch_stall
);
  logic e_ok, m_ok, wb_ok, ld_e_ok, ld_m_ok;
  // destination qualifiers; register 0 never produces a match
  always_comb begin
    e_ok    = reg_write_e && |write_reg_e;
    m_ok    = reg_write_m && |write_reg_m;
    wb_ok   = reg_write_wb && |write_reg_wb;
    ld_e_ok = mem_to_reg_e && |write_reg_e;
    ld_m_ok = mem_to_reg_m && |write_reg_m;
  end
  // forwarding selects (MEM beats WB) and stall conditions
  always_comb begin
    fwd_a_e      = (m_ok && write_reg_m == rs_e) ? FWD_MEM : (wb_ok && write_reg_wb == rs_e) ? FWD_WB : FWD_RF;
    fwd_b_e      = (m_ok && write_reg_m == rt_e) ? FWD_MEM : (wb_ok && write_reg_wb == rt_e) ? FWD_WB : FWD_RF;
    fwd_a_d      = m_ok && write_reg_m == rs_d;
    fwd_b_d      = m_ok && write_reg_m == rt_d;
    load_stall   = ld_e_ok && (write_reg_e == rs_d || write_reg_e == rt_d);
    branch_stall = branch_d && ((e_ok && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                                (ld_m_ok && (write_reg_m == rs_d || write_reg_m == rt_d)));
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control, memory-wait sequencing and stall counter
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_BITS = CPU_def::REG_ADDR_BITS,
  parameter int WAIT_CNT_BITS = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int PERF_BITS = 32
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  import CPU_def::*;
  hz_state_t state_q, state_d;
  logic [WAIT_CNT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic err_q, err_d;
  logic [PERF_BITS-1:0] stall_q, stall_d;
  fwd_sel_t fa_e, fb_e;
  logic fa_d, fb_d, load_stall, branch_stall, mem_wait;
  logic [4:0] en;
  logic [2:0] fl;
  hazard_forward_unit #(.W(REG_ADDR_BITS)) u_fwd (
    .rs_d(bus.rs_d), .rt_d(bus.rt_d), .rs_e(bus.rs_e), .rt_e(bus.rt_e),
    .write_reg_e(bus.write_reg_e), .write_reg_m(bus.write_reg_m), .write_reg_wb(bus.write_reg_wb),
    .reg_write_e(bus.reg_write_e), .reg_write_m(bus.reg_write_m), .reg_write_wb(bus.reg_write_wb),
    .mem_to_reg_e(bus.mem_to_reg_e), .mem_to_reg_m(bus.mem_to_reg_m), .branch_d(bus.branch_d),
    .fwd_a_e(fa_e), .fwd_b_e(fb_e), .fwd_a_d(fa_d), .fwd_b_d(fb_d),
    .load_stall(load_stall), .branch_stall(branch_stall)
  );
  // memory-wait sequencing: entry on a miss, exit on ready, timeout into absorbing ERR
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    if (state_q == RUN && bus.mem_req_m && !bus.mem_ready) begin
      state_d    = MEM_WAIT;
      wait_cnt_d = WAIT_CNT_BITS'(1);
    end else if (state_q == MEM_WAIT && bus.mem_ready) begin
      state_d    = RUN;
      wait_cnt_d = '0;
    end else if (state_q == MEM_WAIT) begin
      wait_cnt_d = wait_cnt_q + WAIT_CNT_BITS'(1);
      if (wait_cnt_d == WAIT_CNT_BITS'(MEM_TIMEOUT)) begin
        state_d = ERR;
        err_d   = 1'b1;
      end
    end
  end
  // enable/flush priority: reset/ERR, memory wait, memory completion, hazard stall, normal
  always_comb begin
    mem_wait = !bus.mem_ready && ((state_q == RUN && bus.mem_req_m) || state_q == MEM_WAIT);
    en = 5'b11111;
    fl = 3'b000;
    if (rst || state_q == ERR) en = '0;
    else if (mem_wait) begin
      en = 5'b00001;
      fl = 3'b001;
    end else if (state_q == RUN && (load_stall || branch_stall)) begin
      en = 5'b00111;
      fl = 3'b010;
    end else if (state_q == RUN) fl[2] = bus.jump_d || (bus.branch_d && bus.branch_taken_d);
    stall_d = stall_q + PERF_BITS'(!en[4]);
  end
  // drive the interface; forwarding is forced to the register file during reset
  always_comb begin
    {bus.en_f, bus.en_d, bus.en_e, bus.en_m, bus.en_wb} = en;
    {bus.flush_d, bus.flush_e, bus.flush_wb} = fl;
    bus.fwd_a_e      = rst ? 2'b00 : fa_e;
    bus.fwd_b_e      = rst ? 2'b00 : fb_e;
    bus.fwd_a_d      = !rst && fa_d;
    bus.fwd_b_d      = !rst && fb_d;
    bus.timeout_err  = err_q;
    bus.stall_cycles = stall_q;
  end
  // state, wait counter, sticky error and stall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
    end
  end
endmodule
